// File: rtl/phase_sequencer.sv
// One-hot instruction-phase generator with per-instruction length, stall,
// single-step, halt and a retired-instruction counter. All outputs registered.
module phase_sequencer #(
  parameter int NUM_PHASES = 12,
  parameter int PHASE_W    = 4,
  parameter int LEN_PHASE  = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic                  stall,
  input  logic                  halt_req,
  input  logic [PHASE_W-1:0]    len_in,
  output logic [NUM_PHASES-1:0] phase,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic                  cycle_start,
  output logic                  cycle_end,
  output logic                  halted,
  output logic [CNT_W-1:0]      instr_count
);

  // state | meaning
  // IDLE  | no instruction in flight, waiting for run or step
  // RUN   | stepping through phases of the current instruction
  // HALT  | stopped for good, only reset leaves
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  localparam logic [PHASE_W-1:0]    LEN_MAX   = PHASE_W'(NUM_PHASES);
  localparam logic [PHASE_W-1:0]    LEN_MIN   = PHASE_W'(LEN_PHASE + 2);
  localparam logic [PHASE_W-1:0]    LEN_IDX   = PHASE_W'(LEN_PHASE);
  localparam logic [NUM_PHASES-1:0] PHASE_ONE = NUM_PHASES'(1);

  state_t                  state_q, state_d;
  logic [PHASE_W-1:0]      idx_q, idx_d;
  logic [PHASE_W-1:0]      len_q, len_d;
  logic                    halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NUM_PHASES-1:0]   phase_q, phase_d;
  logic                    cycle_start_q, cycle_start_d;
  logic                    cycle_end_q, cycle_end_d;
  logic                    halted_q, halted_d;
  logic [PHASE_W-1:0]      end_idx;

  // Phases before the sample point are already spent, so short lengths are
  // stretched to the first phase still ahead of us.
  function automatic logic [PHASE_W-1:0] clamp_len(input logic [PHASE_W-1:0] l);
    if (l == '0 || l > LEN_MAX) return LEN_MAX;
    else if (l < LEN_MIN)       return LEN_MIN;
    else                        return l;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    halt_pend_d = halt_pend_q;
    count_d     = count_q;
    end_idx     = len_q - PHASE_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (run || step) begin
          state_d = ST_RUN;
          idx_d   = '0;
          len_d   = LEN_MAX;
        end
      end
      ST_RUN: begin
        halt_pend_d = halt_pend_q | halt_req;
        if (!stall) begin
          if (idx_q == end_idx) begin
            count_d = count_q + CNT_W'(1);
            idx_d   = '0;
            len_d   = LEN_MAX;
            if (halt_pend_q || halt_req) begin
              state_d     = ST_HALT;
              halt_pend_d = 1'b0;
            end else if (!run) begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + PHASE_W'(1);
            if (idx_q == LEN_IDX) len_d = clamp_len(len_in);
          end
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from next-state values so they land on the same edge.
    phase_d       = (state_d == ST_RUN) ? (PHASE_ONE << idx_d) : '0;
    cycle_start_d = (state_d == ST_RUN) && (idx_d == '0);
    cycle_end_d   = (state_d == ST_RUN) && (idx_d == len_d - PHASE_W'(1));
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      len_q         <= LEN_MAX;
      halt_pend_q   <= 1'b0;
      count_q       <= '0;
      phase_q       <= '0;
      cycle_start_q <= 1'b0;
      cycle_end_q   <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      halt_pend_q   <= halt_pend_d;
      count_q       <= count_d;
      phase_q       <= phase_d;
      cycle_start_q <= cycle_start_d;
      cycle_end_q   <= cycle_end_d;
      halted_q      <= halted_d;
    end
  end

  assign phase       = phase_q;
  assign phase_idx   = idx_q;
  assign cycle_start = cycle_start_q;
  assign cycle_end   = cycle_end_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: stimulus pushes per-cycle expectations,
// a monitor pops and compares them on the falling edge.
module tb_phase_sequencer;

  logic        clk;
  logic        reset;
  logic        run, step, stall, halt_req;
  logic [3:0]  len_in;
  logic [11:0] phase;
  logic [3:0]  phase_idx;
  logic        cycle_start, cycle_end, halted;
  logic [3:0]  instr_count;

  phase_sequencer #(
    .NUM_PHASES(12), .PHASE_W(4), .LEN_PHASE(1), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
    .halt_req(halt_req), .len_in(len_in), .phase(phase), .phase_idx(phase_idx),
    .cycle_start(cycle_start), .cycle_end(cycle_end), .halted(halted),
    .instr_count(instr_count)
  );

  typedef struct {
    int          cyc;
    logic [11:0] phase;
    logic [3:0]  idx;
    logic        cs;
    logic        ce;
    logic        halted;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc_cnt, act, exp);
    end
  endtask

  task automatic check_reset_zero();
    check("rst_phase",       32'(phase),       32'd0);
    check("rst_phase_idx",   32'(phase_idx),   32'd0);
    check("rst_cycle_start", 32'(cycle_start), 32'd0);
    check("rst_cycle_end",   32'(cycle_end),   32'd0);
    check("rst_halted",      32'(halted),      32'd0);
    check("rst_instr_count", 32'(instr_count), 32'd0);
  endtask

  // Monitor: the outputs are valid every cycle, so an expectation tagged for
  // the current cycle is consumed on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc_cnt) begin
          check("stale_entry", 32'(e.cyc), 32'(cyc_cnt));
        end else begin
          check("phase",       32'(phase),       32'(e.phase));
          check("phase_idx",   32'(phase_idx),   32'(e.idx));
          check("cycle_start", 32'(cycle_start), 32'(e.cs));
          check("cycle_end",   32'(cycle_end),   32'(e.ce));
          check("halted",      32'(halted),      32'(e.halted));
          check("instr_count", 32'(instr_count), 32'(e.cnt));
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic drive_cycle(input logic r, input logic s, input logic st, input logic h,
                             input logic [3:0] len, input int e_idx, input logic e_run,
                             input logic e_ce, input logic e_halt, input int e_cnt);
    exp_t        e;
    logic [11:0] one;
    one      = 12'd1;
    run      = r;
    step     = s;
    stall    = st;
    halt_req = h;
    len_in   = len;
    e.cyc    = cyc_cnt + 1;
    e.phase  = e_run ? (one << e_idx) : 12'd0;
    e.idx    = e_run ? 4'(e_idx) : 4'd0;
    e.cs     = e_run && (e_idx == 0);
    e.ce     = e_ce;
    e.halted = e_halt;
    e.cnt    = 4'(e_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input int len_v, input int eff, input int cnt,
                       input logic first_run, input logic first_step, input logic rest_run,
                       input int stall_at, input int stall_n, input int halt_at);
    for (int i = 0; i < eff; i++) begin
      logic r, s, h;
      r = (i == 0) ? first_run : rest_run;
      s = (i == 0) ? first_step : (!rest_run && i == 3);
      h = (i == halt_at);
      drive_cycle(r, s, 1'b0, h, 4'(len_v), i, 1'b1, (i == eff - 1), 1'b0, cnt);
      if (i == stall_at)
        for (int k = 0; k < stall_n; k++)
          drive_cycle(r, 1'b1, 1'b1, 1'b0, 4'(len_v), i, 1'b1, (i == eff - 1), 1'b0, cnt);
    end
  endtask

  int lens[9] = '{12, 12, 5, 1, 15, 0, 2, 3, 13};
  int effs[9] = '{12, 12, 5, 3, 12, 12, 3, 3, 12};

  initial begin
    reset = 1'b0; run = 1'b0; step = 1'b0; stall = 1'b0; halt_req = 1'b0; len_in = 4'd12;
    #3;
    check_reset_zero();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    drive_cycle(0, 0, 0, 0, 12, 0, 0, 0, 0, 0);

    // Free run with assorted decode lengths, back to back.
    for (int j = 0; j < 9; j++) instr(lens[j], effs[j], j, 1, 0, 1, -1, 0, -1);
    // Stall for 3 clocks at idx 6.
    instr(12, 12, 9, 1, 0, 1, 6, 3, -1);
    // run drops mid-instruction; stall on the final phase delays retirement.
    instr(12, 12, 10, 1, 0, 0, 11, 2, -1);
    for (int j = 0; j < 2; j++) drive_cycle(0, 0, 0, 0, 12, 0, 0, 0, 0, 11);
    // Single step; the step pulse at idx 3 is ignored.
    instr(12, 12, 11, 0, 1, 0, -1, 0, -1);
    for (int j = 0; j < 3; j++) drive_cycle(0, 0, 0, 0, 12, 0, 0, 0, 0, 12);
    // Short instructions drive the 4-bit counter through its wrap.
    for (int j = 12; j < 16; j++) instr(3, 3, j, 1, 0, 1, -1, 0, -1);
    // Halt pulse while idx 3; instruction finishes, then HALT.
    instr(12, 12, 0, 1, 0, 1, -1, 0, 4);
    for (int j = 0; j < 4; j++) drive_cycle(1, 1, 1'(j % 2), 0, 12, 0, 0, 0, 1, 1);

    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_zero();
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset mid-instruction at idx 7.
    instr(12, 12, 0, 1, 0, 1, -1, 0, -1);
    for (int i = 0; i < 8; i++) drive_cycle(1, 0, 0, 0, 12, i, 1, 0, 0, 1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_zero();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Restart from phase 0x001, then halt straight from IDLE.
    instr(12, 12, 0, 1, 0, 0, -1, 0, -1);
    drive_cycle(0, 0, 0, 0, 12, 0, 0, 0, 0, 1);
    drive_cycle(1, 0, 0, 1, 12, 0, 0, 0, 1, 1);
    for (int j = 0; j < 2; j++) drive_cycle(1, 1, 0, 0, 12, 0, 0, 0, 1, 1);

    @(negedge clk); #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
